// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with an optional post-byte guard gap and a completion watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CLKS     = 0,
  parameter int unsigned TIMEOUT_CLKS = 4096
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         i_Req_DV,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic [NUM_REQ-1:0]         o_Req_Done,
  output logic                       o_TX_DV,
  output logic [7:0]                 o_TX_Byte,
  input  logic                       i_TX_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
  output logic                       o_Busy,
  output logic                       o_Timeout
);

  localparam int unsigned GW           = $clog2(NUM_REQ);
  localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned CW           = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int unsigned TIMEOUT_LAST = TIMEOUT_CLKS - 1;
  localparam int unsigned GAP_LAST     = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        gap_q, gap_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic [7:0]           req_bytes [NUM_REQ];
  logic                 found;
  logic [GW-1:0]        win;
  logic [GW-1:0]        win_next;

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
    assign req_bytes[n] = i_Req_Byte[8*n +: 8];
  end

  // First requesting index at or after rr_q, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_Req_DV[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
    win_next = (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    ack_d     = '0;
    done_d    = '0;
    grant_d   = grant_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = req_bytes[win];
          ack_d     = NUM_REQ'(1) << win;
          grant_d   = win;
          rr_d      = win_next;
          timer_d   = '0;
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q + TW'(1);
        // A done arriving on the expiry edge still counts as a completion.
        if (i_TX_Done) begin
          done_d  = NUM_REQ'(1) << grant_q;
          gap_d   = '0;
          state_d = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
        end else if (timer_q == TW'(TIMEOUT_LAST)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_GAP: begin
        gap_d = gap_q + CW'(1);
        if (gap_q == CW'(GAP_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_Req_Ack  = ack_q;
  assign o_Req_Done = done_q;
  assign o_Grant_Id = grant_q;
  assign o_Busy     = busy_q;
  assign o_Timeout  = timeout_q;

endmodule
